xram_arbiter: RTL and testbench

Two-requester arbiter sharing the single external data RAM (XDATA, 64 KiB × 8) between the CPU core (port A) and a secondary master such as a program loader or DMA engine (port B). Sits between the requesters and the RAM read/write ports. Grants one access per cycle, registers the winning command onto the RAM ports, and routes synchronous read data back to the owning requester. Port A has fixed priority, and a starvation counter guarantees port B forward progress.

---
 rtl/xram_arbiter.sv | 147 ++++++++++++++
 tb/tb_xram_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/xram_arbiter.sv
// ============================================================================
// Module      : xram_arbiter
// Description : Two-port (A priority, B starvation-protected) arbiter for a
//               single-port-pair 64 KiB x 8 XDATA RAM with read-return routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [7:0]  a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [7:0]  b_rdata,

    output logic        ram_rd_en,
    output logic [15:0] ram_rd_addr,
    input  logic [7:0]  ram_rd_data,
    output logic        ram_wr_en,
    output logic [15:0] ram_wr_addr,
    output logic [7:0]  ram_wr_data
);

    localparam logic [7:0] c_STARVE_MAX = 8'(STARVE_MAX);

    logic [7:0]  r_starve_cnt;
    logic        r_rd_en;
    logic        r_wr_en;
    logic [15:0] r_rd_addr;
    logic [15:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_rd_port;
    logic        r_ret_valid;
    logic        r_ret_port;
    logic [7:0]  r_a_rdata;
    logic [7:0]  r_b_rdata;

    logic        w_b_wins;
    logic        w_a_gnt;
    logic        w_b_gnt;
    logic        w_sel_we;
    logic [15:0] w_sel_addr;
    logic [7:0]  w_sel_wdata;
    logic        w_a_rvalid;
    logic        w_b_rvalid;

    // B wins when alone or once it has been denied STARVE_MAX times in a row
    assign w_b_wins = b_req & (~a_req | (r_starve_cnt == c_STARVE_MAX));
    assign w_b_gnt  = ~rst & w_b_wins;
    assign w_a_gnt  = ~rst & a_req & ~w_b_wins;

    assign w_sel_we    = w_b_gnt ? b_we    : a_we;
    assign w_sel_addr  = w_b_gnt ? b_addr  : a_addr;
    assign w_sel_wdata = w_b_gnt ? b_wdata : a_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 8'd0;
        end else if (w_b_gnt) begin
            r_starve_cnt <= 8'd0;
        end else if (b_req && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // Command stage: address/data registers only move when their strobe fires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_addr <= 16'd0;
            r_wr_addr <= 16'd0;
            r_wr_data <= 8'd0;
            r_rd_port <= 1'b0;
        end else begin
            r_rd_en <= (w_a_gnt | w_b_gnt) & ~w_sel_we;
            r_wr_en <= (w_a_gnt | w_b_gnt) &  w_sel_we;
            if ((w_a_gnt | w_b_gnt) && !w_sel_we) begin
                r_rd_addr <= w_sel_addr;
                r_rd_port <= w_b_gnt;
            end
            if ((w_a_gnt | w_b_gnt) && w_sel_we) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_wdata;
            end
        end
    end

    // Read-return stage: owner tag follows the read by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ret_valid <= 1'b0;
            r_ret_port  <= 1'b0;
        end else begin
            r_ret_valid <= r_rd_en;
            r_ret_port  <= r_rd_port;
        end
    end

    assign w_a_rvalid = r_ret_valid & ~r_ret_port;
    assign w_b_rvalid = r_ret_valid &  r_ret_port;

    // Hold registers keep each port's last returned byte between its reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata <= 8'd0;
            r_b_rdata <= 8'd0;
        end else begin
            if (w_a_rvalid) begin
                r_a_rdata <= ram_rd_data;
            end
            if (w_b_rvalid) begin
                r_b_rdata <= ram_rd_data;
            end
        end
    end

    assign a_gnt       = w_a_gnt;
    assign b_gnt       = w_b_gnt;
    assign a_rvalid    = w_a_rvalid;
    assign b_rvalid    = w_b_rvalid;
    assign a_rdata     = w_a_rvalid ? ram_rd_data : r_a_rdata;
    assign b_rdata     = w_b_rvalid ? ram_rd_data : r_b_rdata;
    assign ram_rd_en   = r_rd_en;
    assign ram_rd_addr = r_rd_addr;
    assign ram_wr_en   = r_wr_en;
    assign ram_wr_addr = r_wr_addr;
    assign ram_wr_data = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_xram_arbiter.sv
// ============================================================================
// Module      : tb_xram_arbiter
// Description : Self-checking bench for xram_arbiter against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xram_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0]  a_rdata, b_rdata;
    logic        ram_rd_en, ram_wr_en;
    logic [15:0] ram_rd_addr, ram_wr_addr;
    logic [7:0]  ram_rd_data, ram_wr_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xram_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
    );

    // Synchronous RAM; mem is touched only with blocking writes
    logic [7:0] mem    [0:65535];
    logic [7:0] shadow [0:65535];

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        if (ram_wr_en) mem[ram_wr_addr] = ram_wr_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: grant rule, one-cycle command pipe, read return, byte-accurate memory image
    int          m_cnt;
    logic        ea, eb, sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wd;
    logic        s1_rd, s1_wr, s1_port, s2_v, s2_port;
    logic [15:0] s1_raddr, s1_waddr;
    logic [7:0]  s1_wdata, s1_rdata, s2_data, m_a_rdata, m_b_rdata;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs",
                {a_gnt, b_gnt, ram_rd_en, ram_wr_en, a_rvalid, b_rvalid,
                 ram_rd_addr, ram_wr_addr, ram_wr_data, a_rdata, b_rdata}, 64'd0);
            m_cnt = 0;
            s1_rd = 0; s1_wr = 0; s1_port = 0; s2_v = 0; s2_port = 0;
            s1_raddr = 0; s1_waddr = 0; s1_wdata = 0; s1_rdata = 0; s2_data = 0;
            m_a_rdata = 0; m_b_rdata = 0;
        end else begin
            eb = b_req && (!a_req || m_cnt >= STARVE);
            ea = a_req && !eb;
            chk("a_gnt", a_gnt, ea);
            chk("b_gnt", b_gnt, eb);
            chk("ram_rd_en", ram_rd_en, s1_rd);
            chk("ram_wr_en", ram_wr_en, s1_wr);
            chk("ram_rd_addr", ram_rd_addr, s1_raddr);
            chk("ram_wr_addr", ram_wr_addr, s1_waddr);
            chk("ram_wr_data", ram_wr_data, s1_wdata);
            chk("a_rvalid", a_rvalid, s2_v && !s2_port);
            chk("b_rvalid", b_rvalid, s2_v && s2_port);
            chk("a_rdata", a_rdata, (s2_v && !s2_port) ? s2_data : m_a_rdata);
            chk("b_rdata", b_rdata, (s2_v && s2_port) ? s2_data : m_b_rdata);

            if (s2_v) begin
                if (s2_port) m_b_rdata = s2_data;
                else         m_a_rdata = s2_data;
            end
            s2_v = s1_rd; s2_port = s1_port; s2_data = s1_rdata;
            s1_rd = 0; s1_wr = 0;
            if (ea || eb) begin
                sel_we   = ea ? a_we    : b_we;
                sel_addr = ea ? a_addr  : b_addr;
                sel_wd   = ea ? a_wdata : b_wdata;
                if (sel_we) begin
                    s1_wr = 1; s1_waddr = sel_addr; s1_wdata = sel_wd;
                    shadow[sel_addr] = sel_wd;
                end else begin
                    s1_rd = 1; s1_raddr = sel_addr; s1_port = eb;
                    s1_rdata = shadow[sel_addr];
                end
            end
            if (eb)                           m_cnt = 0;
            else if (b_req && m_cnt < STARVE) m_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [9:0] ga10, gb10;
    logic [7:0] pat8, v;
    int         rv_cnt;
    logic       ga, gb;

    initial begin
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            shadow[i] = v;
        end
        mem[16'h1234] = 8'h5A;
        shadow[16'h1234] = 8'h5A;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single read on A
        a_req = 1; a_we = 0; a_addr = 16'h1234;
        @(negedge clk); chk("lit_a_gnt_T", a_gnt, 1); chk("lit_b_gnt_T", b_gnt, 0);
        tick(); a_req = 0;
        @(negedge clk); chk("lit_rd_en_T1", ram_rd_en, 1); chk("lit_rd_addr_T1", ram_rd_addr, 16'h1234);
        tick();
        @(negedge clk); chk("lit_a_rvalid_T2", a_rvalid, 1); chk("lit_a_rdata_T2", a_rdata, 8'h5A);
        chk("lit_b_rvalid_T2", b_rvalid, 0);

        // Write then read on B, back-to-back
        tick(); b_req = 1; b_we = 1; b_addr = 16'h0010; b_wdata = 8'hC3;
        @(negedge clk); chk("lit_b_gnt_wr", b_gnt, 1);
        tick(); b_we = 0;
        @(negedge clk); chk("lit_wr_en", ram_wr_en, 1); chk("lit_wr_addr", ram_wr_addr, 16'h0010);
        chk("lit_wr_data", ram_wr_data, 8'hC3);
        tick(); b_req = 0;
        @(negedge clk); chk("lit_rd_en_b", ram_rd_en, 1); chk("lit_rd_addr_b", ram_rd_addr, 16'h0010);
        tick();
        @(negedge clk); chk("lit_b_rvalid", b_rvalid, 1); chk("lit_b_rdata", b_rdata, 8'hC3);
        tick();

        // Continuous contention: AAAAB repeating
        a_req = 1; a_we = 0; a_addr = 16'h0100; b_req = 1; b_we = 0; b_addr = 16'h0200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); ga10[9-i] = a_gnt; gb10[9-i] = b_gnt;
            tick();
        end
        chk("lit_starve_a_pattern", ga10, 10'b1111011110);
        chk("lit_starve_b_pattern", gb10, 10'b0000100001);
        a_req = 0; b_req = 0;
        tick(); tick();

        // B drops its request after 2 denials; count must hold at 2
        a_req = 1; b_req = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) b_req = 0;
            if (i == 5) b_req = 1;
            @(negedge clk); pat8[7-i] = a_gnt;
            tick();
        end
        chk("lit_drop_pattern", pat8, 8'b11111110);
        a_req = 0; b_req = 0;
        repeat (3) tick();

        // Interleaved single-requester reads
        for (int i = 0; i < 16; i++) begin
            a_req = (i % 2 == 0); a_we = 0; a_addr = 16'h0300 + 16'(i);
            b_req = (i % 2 == 1); b_we = 0; b_addr = 16'h0400 + 16'(i);
            tick();
        end
        a_req = 0; b_req = 0;
        repeat (3) tick();

        // Reset with a read in flight
        a_req = 1; a_we = 0; a_addr = 16'h0040;
        @(negedge clk); chk("lit_rst_pre_gnt", a_gnt, 1);
        tick(); a_addr = 16'h0041;
        #2 rst = 1'b1;
        #1 chk("lit_rst_async", {ram_rd_en, a_gnt, a_rvalid, ram_rd_addr}, 64'd0);
        @(posedge clk); #1 rst = 1'b0; a_req = 0;
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); if (a_rvalid) rv_cnt++;
        end
        chk("lit_no_rvalid_after_rst", rv_cnt, 0);
        tick();

        // Randomized traffic with protocol-compliant hold-until-grant
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); ga = a_gnt; gb = b_gnt;
            @(posedge clk); #1;
            if (!a_req || ga) begin
                a_req   = ($urandom_range(0, 99) < 65);
                a_we    = $urandom_range(0, 1) == 1;
                a_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                a_wdata = 8'($urandom);
            end
            if (!b_req || gb) begin
                b_req   = ($urandom_range(0, 99) < 55);
                b_we    = $urandom_range(0, 1) == 1;
                b_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                b_wdata = 8'($urandom);
            end
        end
        @(negedge clk); ga = a_gnt; gb = b_gnt;
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
